check_sequencer: RTL and testbench

- Control FSM for the write-path data checker (generator + error counter) in the non-symmetric write test.
- Clears the error counter and re-seeds the pattern generator, then meters a programmed number of 64-bit words from the receive FIFO into the checker.
- Drains the checker pipeline, latches the final error count and word count, and reports done or timeout to the host-side register block.

---
 rtl/check_sequencer_if.sv | 42 ++++
 rtl/check_sequencer.sv | 153 +++++++++++++++
 tb/tb_check_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/check_sequencer_if.sv
// check_sequencer_if
//   Groups the signals between the check sequencer and the receive FIFO /
//   data checker (pattern generator + error counter).
//
//   data_valid        FIFO -> seq   a word is present on the FIFO output
//   data_ready        seq  -> FIFO  word consumed when data_valid && data_ready
//   error_count[31:0] chk  -> seq   running mismatch count from the checker
//   reset_err_counter seq  -> chk   clear the error counter
//   reset_pattern     seq  -> chk   re-seed the pattern generator
//   enable_pattern    seq  -> chk   advance the generator by one word
//   check_for_errors  seq  -> chk   compare the current word
//
//   master: the sequencer side.  slave: the FIFO/checker side.
interface check_sequencer_if;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] error_count;
  logic        reset_err_counter;
  logic        reset_pattern;
  logic        enable_pattern;
  logic        check_for_errors;

  modport master (
    input  data_valid,
    input  error_count,
    output data_ready,
    output reset_err_counter,
    output reset_pattern,
    output enable_pattern,
    output check_for_errors
  );

  modport slave (
    output data_valid,
    output error_count,
    input  data_ready,
    input  reset_err_counter,
    input  reset_pattern,
    input  enable_pattern,
    input  check_for_errors
  );
endinterface

// File: rtl/check_sequencer.sv
// check_sequencer
//   Control FSM for the write-path data checker. A run clears the error
//   counter and re-seeds the pattern generator, meters a programmed number of
//   64-bit words from the receive FIFO into the checker, drains the checker
//   pipeline, then snapshots the error and word counts for the host.
//
//   clk             system clock
//   reset           synchronous active-high reset
//   start           pulse; begins a run from IDLE or DONE
//   abort           pulse; returns to IDLE from any state (beats start)
//   word_count      words to check, sampled when a run is launched
//   chk             FIFO / checker handshake and strobes (master side)
//   busy            high in CLEAR, CHECK, DRAIN
//   done            high in DONE
//   timeout         sticky; run ended because the FIFO stalled too long
//   errors_latched  error_count snapshot taken at the end of DRAIN
//   words_checked   words accepted during the current/last run
module check_sequencer #(
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              word_count,
  check_sequencer_if.master        chk,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [31:0]              errors_latched,
  output logic [31:0]              words_checked
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CHECK,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
  localparam logic [31:0] STALL_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] remaining;
  logic [31:0] phase_cnt;
  logic [31:0] stall_cnt;

  logic        accept;
  logic        launch;
  logic        last_word;
  logic        stall_hit;
  logic        clear_last;
  logic        drain_last;

  always_comb begin
    state_nxt             = state;
    chk.data_ready        = 1'b0;
    chk.reset_err_counter = 1'b0;
    chk.reset_pattern     = 1'b0;
    chk.enable_pattern    = 1'b0;
    chk.check_for_errors  = 1'b0;
    busy                  = 1'b0;
    done                  = 1'b0;
    accept                = 1'b0;
    launch                = 1'b0;
    last_word             = 1'b0;
    stall_hit             = 1'b0;
    clear_last            = (phase_cnt == CLEAR_LAST);
    drain_last            = (phase_cnt == DRAIN_LAST);

    case (state)
      S_IDLE, S_DONE: begin
        done   = (state == S_DONE);
        launch = start && !abort;
        if (launch) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        busy                  = 1'b1;
        chk.reset_err_counter = 1'b1;
        chk.reset_pattern     = 1'b1;
        // A zero-length run still drains so errors_latched reads a clean 0.
        if (clear_last) state_nxt = (remaining == 32'd0) ? S_DRAIN : S_CHECK;
      end
      S_CHECK: begin
        busy                 = 1'b1;
        chk.data_ready       = 1'b1;
        accept               = chk.data_valid;
        chk.enable_pattern   = accept;
        chk.check_for_errors = accept;
        last_word            = accept && (remaining == 32'd1);
        stall_hit            = TIMEOUT_EN && !accept && (stall_cnt == STALL_LAST);
        if (last_word || stall_hit) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      remaining      <= 32'd0;
      phase_cnt      <= 32'd0;
      stall_cnt      <= 32'd0;
      timeout        <= 1'b0;
      errors_latched <= 32'd0;
      words_checked  <= 32'd0;
    end else begin
      state <= state_nxt;

      // Phase counter times CLEAR and DRAIN; restarts on every state change.
      if (state_nxt != state) phase_cnt <= 32'd0;
      else if (state == S_CLEAR || state == S_DRAIN) phase_cnt <= phase_cnt + 32'd1;

      if (state == S_CHECK && !accept) stall_cnt <= stall_cnt + 32'd1;
      else                             stall_cnt <= 32'd0;

      // A word presented in the abort cycle has already left the FIFO, so it
      // is still counted.
      if (accept) begin
        words_checked <= words_checked + 32'd1;
        remaining     <= remaining - 32'd1;
      end

      if (launch) begin
        remaining     <= word_count;
        words_checked <= 32'd0;
        timeout       <= 1'b0;
      end

      if (stall_hit) timeout <= 1'b1;

      // error_count trails check_for_errors by one clock; sampling at the end
      // of DRAIN therefore includes the final compare.
      if (state == S_DRAIN && drain_last && !abort) errors_latched <= chk.error_count;

      if (abort) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_check_sequencer.sv
module tb_check_sequencer;
  localparam int CLR = 2;
  localparam int DRN = 2;
  localparam int TMO = 16;

  typedef logic [6:0] ovec_t;

  typedef struct {
    bit    st;
    bit    dv;
    bit    cor;
    ovec_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] word_count;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] errors_latched;
  logic [31:0] words_checked;
  logic        corrupt;
  logic [31:0] err_cnt;
  ovec_t       outs;

  int n_checks = 0;
  int n_errors = 0;

  bit          vq[$];
  bit          cq[$];
  bit          prev_done;

  check_sequencer_if ifc ();

  check_sequencer #(
    .CLEAR_CYCLES  (CLR),
    .DRAIN_CYCLES  (DRN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .word_count    (word_count),
    .chk           (ifc),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .errors_latched(errors_latched),
    .words_checked (words_checked)
  );

  always #5 clk = ~clk;

  // Behavioural checker: counts corrupted words one clock after the compare.
  always_ff @(posedge clk) begin
    if (reset || ifc.reset_err_counter) err_cnt <= 32'd0;
    else if (ifc.check_for_errors && corrupt) err_cnt <= err_cnt + 32'd1;
  end
  assign ifc.error_count = err_cnt;

  assign outs = {busy, done, ifc.data_ready, ifc.enable_pattern, ifc.check_for_errors,
                 ifc.reset_err_counter, ifc.reset_pattern};

  // {busy, done, data_ready, enable_pattern, check_for_errors, reset_err_counter, reset_pattern}
  function automatic ovec_t mk(bit b, bit d, bit r, bit e, bit c);
    return {b, d, r, e, e, c, c};
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkv(input string nm, input ovec_t act, input ovec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: outputs got %b, expected %b (busy,done,rdy,en,chk,rerr,rpat)", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, compare outputs before the edge, then advance.
  task automatic cyc(input bit st, input bit ab, input bit dv, input bit cor,
                     input logic [31:0] wc, input ovec_t exp, input string nm);
    start = st; abort = ab; ifc.data_valid = dv; corrupt = cor; word_count = wc;
    #1;
    checkv(nm, outs, exp);
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; ifc.data_valid = 1'b0; corrupt = 1'b0; word_count = 32'd0;
  endtask

  // Run-level reference: expected per-cycle outputs derived from the run rules
  // (clear length, accept-until-count-or-stall, drain length), then final counts.
  task automatic run(input logic [31:0] n, input bit noisy, input string nm);
    int unsigned acc;
    int          stall;
    int unsigned errs;
    int          k;
    bit          to;
    bit          v;
    bit          c;
    acc = 0; stall = 0; errs = 0; k = 0; to = 0;
    cyc(1'b1, 1'b0, 1'($urandom), 1'b0, n, mk(0, prev_done, 0, 0, 0), {nm, " launch"});
    for (int i = 0; i < CLR; i++)
      cyc(noisy & 1'($urandom), 1'b0, 1'($urandom), 1'b0, $urandom, mk(1, 0, 0, 0, 1), {nm, " clear"});
    if (n != 32'd0) begin
      while (1) begin
        v = (k < vq.size()) ? vq[k] : 1'b0;
        c = (k < cq.size()) ? cq[k] : 1'b0;
        cyc(noisy & 1'($urandom), 1'b0, v, c, $urandom, mk(1, 0, 1, v, 0), {nm, " check"});
        k++;
        if (v) begin
          acc++;
          if (c) errs++;
          stall = 0;
          if (acc == n) break;
        end else begin
          stall++;
          if (stall == TMO) begin
            to = 1'b1;
            break;
          end
        end
      end
    end
    for (int i = 0; i < DRN; i++)
      cyc(noisy & 1'($urandom), 1'b0, 1'($urandom), 1'b0, $urandom, mk(1, 0, 0, 0, 0), {nm, " drain"});
    idle_inputs();
    #1;
    checkv({nm, " done"}, outs, mk(0, 1, 0, 0, 0));
    check32({nm, " words_checked"}, words_checked, acc);
    check32({nm, " errors_latched"}, errors_latched, errs);
    check32({nm, " timeout"}, {31'd0, timeout}, {31'd0, to});
    @(posedge clk); #1;
    prev_done = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    int   n;
    int   p;
    int   len;
    int   gap;

    // Reset state
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checkv("reset outputs", outs, mk(0, 0, 0, 0, 0));
    check32("reset words_checked", words_checked, 32'd0);
    check32("reset errors_latched", errors_latched, 32'd0);
    check32("reset timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    prev_done = 1'b0;

    // Table: word_count=4, data_valid gaps, one corrupted word
    tbl[0]  = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 1)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 1)};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, mk(1, 0, 1, 1, 0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, mk(1, 0, 1, 1, 0)};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, mk(1, 0, 1, 1, 0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, mk(1, 0, 1, 0, 0)};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, mk(1, 0, 1, 1, 0)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0)};
    tbl[12] = '{1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0, 0)};
    for (int i = 0; i < 13; i++)
      cyc(tbl[i].st, 1'b0, tbl[i].dv, tbl[i].cor, 32'd4, tbl[i].exp, $sformatf("table row %0d", i));
    check32("table words_checked", words_checked, 32'd4);
    check32("table errors_latched", errors_latched, 32'd1);
    prev_done = 1'b1;

    // 8 back-to-back words, clean then with 3 corrupted
    vq.delete(); cq.delete();
    for (int i = 0; i < 8; i++) begin vq.push_back(1'b1); cq.push_back(1'b0); end
    run(32'd8, 1'b0, "clean8");
    cq.delete();
    for (int i = 0; i < 8; i++) cq.push_back(i == 1 || i == 4 || i == 7);
    run(32'd8, 1'b1, "dirty8");

    // Zero-length run
    vq.delete(); cq.delete();
    run(32'd0, 1'b0, "zero");

    // Stall timeout after 3 of 10 words
    vq.delete(); cq.delete();
    for (int i = 0; i < 3; i++) begin vq.push_back(1'b1); cq.push_back(i == 2); end
    run(32'd10, 1'b0, "timeout");

    // Abort from DONE clears timeout, keeps counts
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, mk(0, 1, 0, 0, 0), "abort in done");
    idle_inputs(); #1;
    checkv("after abort idle", outs, mk(0, 0, 0, 0, 0));
    check32("abort clears timeout", {31'd0, timeout}, 32'd0);
    check32("abort keeps words", words_checked, 32'd3);
    check32("abort keeps errors", errors_latched, 32'd1);
    @(posedge clk); #1;

    // start and abort together from IDLE
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd5, mk(0, 0, 0, 0, 0), "start+abort cycle");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd5, mk(0, 0, 0, 0, 0), "start+abort stays idle");

    // Abort in CHECK after 5 of 20 words
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd20, mk(0, 0, 0, 0, 0), "abortrun launch");
    for (int i = 0; i < CLR; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd20, mk(1, 0, 0, 0, 1), "abortrun clear");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd20, mk(1, 0, 1, 1, 0), "abortrun check");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd20, mk(1, 0, 1, 0, 0), "abortrun abort");
    idle_inputs(); #1;
    checkv("abortrun idle", outs, mk(0, 0, 0, 0, 0));
    check32("abortrun words", words_checked, 32'd5);
    @(posedge clk); #1;
    prev_done = 1'b0;
    vq.delete(); cq.delete();
    vq.push_back(1'b1); vq.push_back(1'b1); cq.push_back(1'b0); cq.push_back(1'b1);
    run(32'd2, 1'b0, "after abort");

    // Maximum word_count: stalls out, no wrap
    vq.delete(); cq.delete();
    for (int i = 0; i < 3; i++) begin vq.push_back(1'b1); cq.push_back(1'b0); end
    run(32'hFFFF_FFFF, 1'b1, "maxcount");

    // Reset in the middle of a run
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd6, mk(0, 1, 0, 0, 0), "midreset launch");
    for (int i = 0; i < CLR; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd6, mk(1, 0, 0, 0, 1), "midreset clear");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd6, mk(1, 0, 1, 1, 0), "midreset check");
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd6, mk(1, 0, 1, 0, 0), "midreset assert");
    reset = 1'b0;
    idle_inputs(); #1;
    checkv("midreset outputs", outs, mk(0, 0, 0, 0, 0));
    check32("midreset words", words_checked, 32'd0);
    check32("midreset errors", errors_latched, 32'd0);
    @(posedge clk); #1;
    prev_done = 1'b0;

    // Randomized runs, some with a stall stretch around the timeout limit
    for (int r = 0; r < 30; r++) begin
      vq.delete(); cq.delete();
      n   = (r % 7 == 3) ? 0 : $urandom_range(1, 12);
      p   = $urandom_range(40, 95);
      len = n * 4 + 8;
      gap = (r % 4 == 0) ? $urandom_range(TMO - 2, TMO + 1) : 0;
      for (int i = 0; i < len; i++) begin
        if (i == n / 2)
          for (int g = 0; g < gap; g++) begin vq.push_back(1'b0); cq.push_back(1'b0); end
        vq.push_back($urandom_range(0, 99) < p);
        cq.push_back($urandom_range(0, 99) < 25);
      end
      run(n, 1'($urandom), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
